cdb_arbiter: RTL and testbench

Common-data-bus arbiter between the execution units and the reorder buffer. It accepts completed results from the ALU/reservation-station side and the load-store buffer side, each through its own small FIFO. Each cycle it grants at most one result onto a single registered broadcast bus. That bus feeds the ROB result port and the RS/LSB operand-wakeup logic, so at most one result is written per cycle.

---
 rtl/cdb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - CDB arbiter: two result FIFOs (ALU, LSB) onto one registered broadcast bus
// Optional CDB_FIXED_PRIO_EN: LSB always wins over ALU, round-robin state removed.
module cdb_arbiter #(
    parameter int ROB_ID_W = 3,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                clear,
    input  logic                alu_valid,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [31:0]         alu_value,
    output logic                alu_ready,
    input  logic                lsb_valid,
    input  logic [ROB_ID_W-1:0] lsb_rob_id,
    input  logic [31:0]         lsb_value,
    output logic                lsb_ready,
    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [31:0]         cdb_value,
    output logic                cdb_src
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ROB_ID_W + 32;

    logic [EW-1:0]       alu_mem_q [DEPTH];
    logic [EW-1:0]       alu_mem_d [DEPTH];
    logic [EW-1:0]       lsb_mem_q [DEPTH];
    logic [EW-1:0]       lsb_mem_d [DEPTH];
    logic [PW-1:0]       alu_head_q, alu_head_d, alu_tail_q, alu_tail_d;
    logic [PW-1:0]       lsb_head_q, lsb_head_d, lsb_tail_q, lsb_tail_d;
    logic [CW-1:0]       alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
    logic                cdb_valid_q, cdb_valid_d;
    logic [ROB_ID_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic [31:0]         cdb_value_q, cdb_value_d;
    logic                cdb_src_q, cdb_src_d;
`ifndef CDB_FIXED_PRIO_EN
    logic                rr_q, rr_d;
`endif

    logic do_op, alu_enq, lsb_enq, alu_ne, lsb_ne, grant_alu, grant_lsb;
    logic [EW-1:0] alu_head_entry, lsb_head_entry;

    assign alu_ready      = (alu_cnt_q < CW'(DEPTH));
    assign lsb_ready      = (lsb_cnt_q < CW'(DEPTH));
    assign do_op          = rdy && !clear;
    assign alu_enq        = do_op && alu_valid && alu_ready;
    assign lsb_enq        = do_op && lsb_valid && lsb_ready;
    assign alu_ne         = (alu_cnt_q != '0);
    assign lsb_ne         = (lsb_cnt_q != '0);
    assign alu_head_entry = alu_mem_q[alu_head_q];
    assign lsb_head_entry = lsb_mem_q[lsb_head_q];

    // Only registered counts are consulted, so a same-cycle enqueue is never granted.
`ifdef CDB_FIXED_PRIO_EN
    assign grant_lsb = do_op && lsb_ne;
    assign grant_alu = do_op && alu_ne && !lsb_ne;
`else
    assign grant_alu = do_op && alu_ne && (!lsb_ne || !rr_q);
    assign grant_lsb = do_op && lsb_ne && (!alu_ne || rr_q);
`endif

    always_comb begin
        alu_mem_d    = alu_mem_q;
        lsb_mem_d    = lsb_mem_q;
        alu_head_d   = alu_head_q;
        alu_tail_d   = alu_tail_q;
        lsb_head_d   = lsb_head_q;
        lsb_tail_d   = lsb_tail_q;
        alu_cnt_d    = alu_cnt_q;
        lsb_cnt_d    = lsb_cnt_q;
        cdb_valid_d  = cdb_valid_q;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_value_d  = cdb_value_q;
        cdb_src_d    = cdb_src_q;
`ifndef CDB_FIXED_PRIO_EN
        rr_d         = rr_q;
`endif
        if (rdy && clear) begin
            alu_head_d  = '0;
            alu_tail_d  = '0;
            lsb_head_d  = '0;
            lsb_tail_d  = '0;
            alu_cnt_d   = '0;
            lsb_cnt_d   = '0;
            cdb_valid_d = 1'b0;
`ifndef CDB_FIXED_PRIO_EN
            rr_d        = 1'b0;
`endif
        end else if (rdy) begin
            cdb_valid_d = grant_alu || grant_lsb;
            if (grant_alu) begin
                {cdb_rob_id_d, cdb_value_d} = alu_head_entry;
                cdb_src_d  = 1'b0;
                alu_head_d = alu_head_q + PW'(1);
`ifndef CDB_FIXED_PRIO_EN
                rr_d       = 1'b1;
`endif
            end else if (grant_lsb) begin
                {cdb_rob_id_d, cdb_value_d} = lsb_head_entry;
                cdb_src_d  = 1'b1;
                lsb_head_d = lsb_head_q + PW'(1);
`ifndef CDB_FIXED_PRIO_EN
                rr_d       = 1'b0;
`endif
            end
            if (alu_enq) begin
                alu_mem_d[alu_tail_q] = {alu_rob_id, alu_value};
                alu_tail_d            = alu_tail_q + PW'(1);
            end
            if (lsb_enq) begin
                lsb_mem_d[lsb_tail_q] = {lsb_rob_id, lsb_value};
                lsb_tail_d            = lsb_tail_q + PW'(1);
            end
            alu_cnt_d = alu_cnt_q + CW'(alu_enq) - CW'(grant_alu);
            lsb_cnt_d = lsb_cnt_q + CW'(lsb_enq) - CW'(grant_lsb);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                alu_mem_q[i] <= '0;
                lsb_mem_q[i] <= '0;
            end
            alu_head_q   <= '0;
            alu_tail_q   <= '0;
            lsb_head_q   <= '0;
            lsb_tail_q   <= '0;
            alu_cnt_q    <= '0;
            lsb_cnt_q    <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_rob_id_q <= '0;
            cdb_value_q  <= '0;
            cdb_src_q    <= 1'b0;
`ifndef CDB_FIXED_PRIO_EN
            rr_q         <= 1'b0;
`endif
        end else begin
            alu_mem_q    <= alu_mem_d;
            lsb_mem_q    <= lsb_mem_d;
            alu_head_q   <= alu_head_d;
            alu_tail_q   <= alu_tail_d;
            lsb_head_q   <= lsb_head_d;
            lsb_tail_q   <= lsb_tail_d;
            alu_cnt_q    <= alu_cnt_d;
            lsb_cnt_q    <= lsb_cnt_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_value_q  <= cdb_value_d;
            cdb_src_q    <= cdb_src_d;
`ifndef CDB_FIXED_PRIO_EN
            rr_q         <= rr_d;
`endif
        end
    end

    assign cdb_valid  = cdb_valid_q;
    assign cdb_rob_id = cdb_rob_id_q;
    assign cdb_value  = cdb_value_q;
    assign cdb_src    = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized self-checking bench for cdb_arbiter against a queue-based model
module tb_cdb_arbiter;
    localparam int ROB_ID_W = 3;
    localparam int DEPTH    = 2;
    localparam int EW       = ROB_ID_W + 32;

    typedef logic [EW-1:0] entry_t;
    typedef logic [EW:0]   bcast_t;

    logic clk = 1'b0;
    logic rst, rdy, clear;
    logic alu_valid, lsb_valid, alu_ready, lsb_ready;
    logic [ROB_ID_W-1:0] alu_rob_id, lsb_rob_id, cdb_rob_id;
    logic [31:0] alu_value, lsb_value, cdb_value;
    logic cdb_valid, cdb_src;

    int n_pass = 0;
    int n_total = 0;

    entry_t m_alu[$], m_lsb[$];
    logic m_rr, m_valid, m_src;
    logic [ROB_ID_W-1:0] m_rob;
    logic [31:0] m_val;
    entry_t s_alu[$], s_lsb[$];
    bcast_t got[$];

    always #5 clk = ~clk;

    cdb_arbiter #(.ROB_ID_W(ROB_ID_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value), .alu_ready(alu_ready),
        .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value), .lsb_ready(lsb_ready),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value), .cdb_src(cdb_src)
    );

    task automatic model_reset();
        m_alu.delete();
        m_lsb.delete();
        m_rr = 1'b0;
        m_valid = 1'b0;
        m_src = 1'b0;
        m_rob = '0;
        m_val = '0;
    endtask

    // One rising edge of the reference: one winner from the pre-edge queues, then new arrivals.
    task automatic model_step();
        bit ae, le, ga, gl;
        entry_t e;
        if (!rdy) return;
        if (clear) begin
            m_alu.delete();
            m_lsb.delete();
            m_valid = 1'b0;
            m_rr = 1'b0;
            return;
        end
        ae = alu_valid && (m_alu.size() < DEPTH);
        le = lsb_valid && (m_lsb.size() < DEPTH);
`ifdef CDB_FIXED_PRIO_EN
        gl = (m_lsb.size() > 0);
        ga = !gl && (m_alu.size() > 0);
`else
        if (m_alu.size() > 0 && m_lsb.size() > 0) begin
            ga = !m_rr;
            gl = m_rr;
        end else begin
            ga = (m_alu.size() > 0);
            gl = (m_lsb.size() > 0);
        end
`endif
        if (ga) begin
            e = m_alu.pop_front();
            {m_rob, m_val} = e;
            m_valid = 1'b1;
            m_src = 1'b0;
            m_rr = 1'b1;
        end else if (gl) begin
            e = m_lsb.pop_front();
            {m_rob, m_val} = e;
            m_valid = 1'b1;
            m_src = 1'b1;
            m_rr = 1'b0;
        end else begin
            m_valid = 1'b0;
        end
        if (ae) m_alu.push_back({alu_rob_id, alu_value});
        if (le) m_lsb.push_back({lsb_rob_id, lsb_value});
    endtask

    // Producers hold the head of s_alu/s_lsb until it is taken (or flushed away).
    task automatic drive_cycle();
        bit acc_a, acc_l, r;
        alu_valid = (s_alu.size() > 0);
        lsb_valid = (s_lsb.size() > 0);
        if (alu_valid) {alu_rob_id, alu_value} = s_alu[0];
        if (lsb_valid) {lsb_rob_id, lsb_value} = s_lsb[0];
        acc_a = rdy && alu_valid && (clear || m_alu.size() < DEPTH);
        acc_l = rdy && lsb_valid && (clear || m_lsb.size() < DEPTH);
        r = rdy;
        @(posedge clk);
        model_step();
        #1;
        if (acc_a) s_alu.delete(0);
        if (acc_l) s_lsb.delete(0);
        if (r && cdb_valid) got.push_back({cdb_src, cdb_rob_id, cdb_value});
    endtask

    task automatic flush_pulse();
        s_alu.delete();
        s_lsb.delete();
        clear = 1'b1;
        drive_cycle();
        clear = 1'b0;
        got.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({cdb_valid, alu_ready, lsb_ready, cdb_src} !== 4'b0110)
            $display("FAIL reset_flags got %b want 0110", {cdb_valid, alu_ready, lsb_ready, cdb_src});
        else n_pass++;
        n_total++;
        if ({cdb_rob_id, cdb_value} !== '0)
            $display("FAIL reset_data got %h want 0", {cdb_rob_id, cdb_value});
        else n_pass++;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_alu.push_back({3'(i), 32'hAA00_0000 + i});
            s_lsb.push_back({3'(i + 4), 32'hBB00_0000 + i});
        end
        repeat (3) drive_cycle();
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if ({cdb_valid, alu_ready, lsb_ready} !== 3'b011)
            $display("FAIL reset_async got %b want 011", {cdb_valid, alu_ready, lsb_ready});
        else n_pass++;
        model_reset();
        s_alu.delete();
        s_lsb.delete();
        alu_valid = 1'b0;
        lsb_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        s_alu.push_back({3'd3, 32'h1234_5678});
        drive_cycle();
        n_total++;
        if (cdb_valid !== 1'b0) $display("FAIL single_no_bypass got %b want 0", cdb_valid);
        else n_pass++;
        drive_cycle();
        n_total++;
        if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== {1'b1, 1'b0, 3'd3, 32'h1234_5678})
            $display("FAIL single_bcast got %b %b %0d %h want 1 0 3 12345678",
                     cdb_valid, cdb_src, cdb_rob_id, cdb_value);
        else n_pass++;
        drive_cycle();
        n_total++;
        if (cdb_valid !== 1'b0) $display("FAIL single_one_cycle got %b want 0", cdb_valid);
        else n_pass++;
    endtask

    task automatic test_contention();
        bcast_t exp[6];
        flush_pulse();
        for (int i = 0; i < 3; i++) begin
            s_alu.push_back({3'(i), 32'hA0 + i});
            s_lsb.push_back({3'(i + 4), 32'hB4 + i});
        end
`ifdef CDB_FIXED_PRIO_EN
        for (int i = 0; i < 3; i++) begin
            exp[i]     = {1'b1, 3'(i + 4), 32'hB4 + i};
            exp[i + 3] = {1'b0, 3'(i), 32'hA0 + i};
        end
`else
        for (int i = 0; i < 3; i++) begin
            exp[2 * i]     = {1'b0, 3'(i), 32'hA0 + i};
            exp[2 * i + 1] = {1'b1, 3'(i + 4), 32'hB4 + i};
        end
`endif
        for (int c = 0; c < 20 && got.size() < 6; c++) drive_cycle();
        n_total++;
        if (got.size() != 6) $display("FAIL contention_count got %0d want 6", got.size());
        else n_pass++;
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_total++;
            if (got[i] !== exp[i]) $display("FAIL contention_order[%0d] got %h want %h", i, got[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_full_wrap();
        entry_t sa[$], sl[$];
        bit saw_full;
        int ia, il;
        flush_pulse();
        for (int i = 0; i < 6; i++) begin
            s_alu.push_back({3'(i), $urandom()});
            s_lsb.push_back({3'(7 - i), $urandom()});
        end
        sa = s_alu;
        sl = s_lsb;
        saw_full = 1'b0;
        for (int c = 0; c < 40 && got.size() < 12; c++) begin
            drive_cycle();
`ifdef CDB_FIXED_PRIO_EN
            if (!alu_ready) saw_full = 1'b1;
`else
            if (!lsb_ready) saw_full = 1'b1;
`endif
        end
        n_total++;
        if (saw_full !== 1'b1) $display("FAIL full_ready_drop got %b want 1", saw_full);
        else n_pass++;
        n_total++;
        if (got.size() != 12) $display("FAIL wrap_count got %0d want 12", got.size());
        else n_pass++;
        ia = 0;
        il = 0;
        foreach (got[i]) begin
            n_total++;
            if (got[i][EW] == 1'b0) begin
                if (ia < sa.size() && got[i][EW-1:0] === sa[ia]) n_pass++;
                else $display("FAIL wrap_alu_order[%0d] got %h", ia, got[i][EW-1:0]);
                ia++;
            end else begin
                if (il < sl.size() && got[i][EW-1:0] === sl[il]) n_pass++;
                else $display("FAIL wrap_lsb_order[%0d] got %h", il, got[i][EW-1:0]);
                il++;
            end
        end
    endtask

    task automatic test_flush();
        flush_pulse();
        for (int i = 0; i < 4; i++) begin
            s_alu.push_back({3'(i), 32'hC0 + i});
            s_lsb.push_back({3'(i + 4), 32'hD0 + i});
        end
        repeat (3) drive_cycle();
        clear = 1'b1;
        drive_cycle();
        clear = 1'b0;
        n_total++;
        if ({cdb_valid, alu_ready, lsb_ready} !== 3'b011)
            $display("FAIL flush_state got %b want 011", {cdb_valid, alu_ready, lsb_ready});
        else n_pass++;
        s_alu.delete();
        s_lsb.delete();
        got.delete();
        repeat (2) drive_cycle();
        n_total++;
        if (got.size() != 0) $display("FAIL flush_dropped got %0d broadcasts want 0", got.size());
        else n_pass++;
        s_alu.push_back({3'd1, 32'hE1});
        s_lsb.push_back({3'd2, 32'hE2});
        repeat (4) drive_cycle();
        n_total++;
`ifdef CDB_FIXED_PRIO_EN
        if (got.size() != 2 || got[0] !== {1'b1, 3'd2, 32'hE2})
`else
        if (got.size() != 2 || got[0] !== {1'b0, 3'd1, 32'hE1})
`endif
            $display("FAIL flush_rr_reset got n=%0d first=%h", got.size(), got.size() > 0 ? got[0] : '0);
        else n_pass++;
    endtask

    task automatic test_stall();
        entry_t sa[$], sl[$];
        logic [EW+3:0] held;
        int ia, il;
        flush_pulse();
        for (int i = 0; i < 4; i++) begin
            s_alu.push_back({3'(i), $urandom()});
            s_lsb.push_back({3'(i + 4), $urandom()});
        end
        sa = s_alu;
        sl = s_lsb;
        for (int c = 0; c < 5 && cdb_valid !== 1'b1; c++) drive_cycle();
        held = {cdb_valid, cdb_src, alu_ready, lsb_ready, cdb_rob_id, cdb_value};
        n_total++;
        if (held[EW+3] !== 1'b1) $display("FAIL stall_setup got %b want 1", held[EW+3]);
        else n_pass++;
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_cycle();
            n_total++;
            if ({cdb_valid, cdb_src, alu_ready, lsb_ready, cdb_rob_id, cdb_value} !== held)
                $display("FAIL stall_frozen[%0d] got %h want %h", c,
                         {cdb_valid, cdb_src, alu_ready, lsb_ready, cdb_rob_id, cdb_value}, held);
            else n_pass++;
        end
        rdy = 1'b1;
        for (int c = 0; c < 20 && got.size() < 8; c++) drive_cycle();
        n_total++;
        if (got.size() != 8) $display("FAIL stall_count got %0d want 8", got.size());
        else n_pass++;
        ia = 0;
        il = 0;
        foreach (got[i]) begin
            n_total++;
            if (got[i][EW] == 1'b0) begin
                if (ia < sa.size() && got[i][EW-1:0] === sa[ia]) n_pass++;
                else $display("FAIL stall_alu_order[%0d] got %h", ia, got[i][EW-1:0]);
                ia++;
            end else begin
                if (il < sl.size() && got[i][EW-1:0] === sl[il]) n_pass++;
                else $display("FAIL stall_lsb_order[%0d] got %h", il, got[i][EW-1:0]);
                il++;
            end
        end
    endtask

    task automatic test_random();
        flush_pulse();
        for (int c = 0; c < 400; c++) begin
            rdy   = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 39) == 0);
            if (s_alu.size() < 2 && $urandom_range(0, 1) == 1) s_alu.push_back({3'($urandom()), $urandom()});
            if (s_lsb.size() < 2 && $urandom_range(0, 1) == 1) s_lsb.push_back({3'($urandom()), $urandom()});
            drive_cycle();
            n_total++;
            if ({cdb_valid, cdb_src} !== {m_valid, m_src})
                $display("FAIL rand_valid_src[%0d] got %b%b want %b%b", c, cdb_valid, cdb_src, m_valid, m_src);
            else n_pass++;
            n_total++;
            if ({cdb_rob_id, cdb_value} !== {m_rob, m_val})
                $display("FAIL rand_data[%0d] got %h want %h", c, {cdb_rob_id, cdb_value}, {m_rob, m_val});
            else n_pass++;
            n_total++;
            if ({alu_ready, lsb_ready} !== {m_alu.size() < DEPTH, m_lsb.size() < DEPTH})
                $display("FAIL rand_ready[%0d] got %b%b want %b%b", c, alu_ready, lsb_ready,
                         m_alu.size() < DEPTH, m_lsb.size() < DEPTH);
            else n_pass++;
        end
        rdy = 1'b1;
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        clear = 1'b0;
        alu_valid = 1'b0;
        lsb_valid = 1'b0;
        alu_rob_id = '0;
        lsb_rob_id = '0;
        alu_value = '0;
        lsb_value = '0;
        test_reset();
        test_contention();
        test_full_wrap();
        test_flush();
        test_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
